// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: credit-limited request/grant/response fetch into a
// registered prefetch FIFO of {pc, inst}, with redirect flush and stale-response drop.
module inst_fetch_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam int                CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];
  logic [INST_W-1:0] fifo_inst_q [DEPTH];
  logic [INST_W-1:0] fifo_inst_d [DEPTH];

  logic [CNT_W:0] credits_used;
  logic           issue;
  logic           resp;
  logic           push;
  logic           pop;

  // Credits count both in-flight and buffered fetches, so a push can never hit a full FIFO.
  always_comb begin
    credits_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    mem_req_o    = !redirect_i && (credits_used < (CNT_W + 1)'(DEPTH));
    mem_addr_o   = fetch_pc_q;
    inst_valid_o = (fifo_cnt_q != '0) && !redirect_i;
    inst_o       = fifo_inst_q[rd_ptr_q];
    inst_pc_o    = fifo_pc_q[rd_ptr_q];
    issue        = mem_req_o && mem_gnt_i;
    resp         = mem_rvalid_i && (out_cnt_q != '0);
    push         = resp && (drop_cnt_q == '0) && !redirect_i;
    pop          = inst_valid_o && inst_ready_i;
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    out_cnt_d   = out_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;

    if (redirect_i) begin
      // Everything still outstanding is stale, including nothing that returns this cycle.
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      out_cnt_d  = out_cnt_q - CNT_W'(resp);
      drop_cnt_d = out_cnt_q - CNT_W'(resp);
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
      out_cnt_d = out_cnt_q + CNT_W'(issue) - CNT_W'(resp);
      if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = resp_pc_q;
        fifo_inst_d[wr_ptr_q] = mem_rdata_i;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        resp_pc_d             = resp_pc_q + PC_INC;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      // NOTE: FIFO storage is reset so inst_o/inst_pc_o read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: directed test-plan scenarios plus random
// traffic, checked against a transaction-level model of fetches, in-flight list and FIFO.
module tb_inst_fetch_bridge;

  localparam int          AW  = 32;
  localparam int          IW  = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic          inst_valid_o;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_ready_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [IW-1:0] mem_rdata_i;

  inst_fetch_bridge #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;

  flight_t     fl_q[$];
  entry_t      fifo_m[$];
  logic [31:0] m_fetch_pc;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          total = 0;
  int          bad = 0;
  int          grants = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic int get_lat();
    if (lat_min == lat_max) return lat_min;
    return int'($urandom_range(lat_max, lat_min));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fl_q.delete();
    fifo_m.delete();
    m_fetch_pc = RPC;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic tick(input bit redir, input logic [31:0] rpc, input bit ready,
                      input bit gnt, input bit bogus_rv);
    bit          exp_req, exp_valid, rv;
    logic [31:0] rdata;
    flight_t     f;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    inst_ready_i  = ready;
    mem_gnt_i     = gnt;
    rv            = (fl_q.size() != 0) && (fl_q[0].due <= cyc);
    rdata         = rv ? mem_word(fl_q[0].addr) : $urandom;
    if (bogus_rv && fl_q.size() == 0) rv = 1'b1;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rdata;
    #1;
    exp_req   = !redir && (fl_q.size() + fifo_m.size() < D);
    exp_valid = !redir && (fifo_m.size() != 0);
    chk("mem_req", 64'(mem_req_o), 64'(exp_req));
    if (exp_req) chk("mem_addr", 64'(mem_addr_o), 64'(m_fetch_pc));
    chk("inst_valid", 64'(inst_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      chk("inst_pc", 64'(inst_pc_o), 64'(fifo_m[0].pc));
      chk("inst", 64'(inst_o), 64'(fifo_m[0].inst));
    end
    if (mem_req_o && gnt) grants++;
    if (rv && fl_q.size() != 0) begin
      f = fl_q.pop_front();
      if (!f.stale && !redir) fifo_m.push_back('{pc: f.addr, inst: mem_word(f.addr)});
    end
    if (redir) begin
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      fifo_m.delete();
      m_fetch_pc = rpc;
    end else begin
      if (exp_valid && ready) void'(fifo_m.pop_front());
      if (exp_req && gnt) begin
        fl_q.push_back('{addr: m_fetch_pc, due: cyc + get_lat(), stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rp;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    model_reset();
    #2;
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_pc", 64'(inst_pc_o), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd1);
    chk("rst_addr", 64'(mem_addr_o), 64'(RPC));
    @(posedge clk); #1;
    rst = 1'b0;

    // Stream: L=1, grant and ready every cycle.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-pressure: exactly DEPTH grants, then request drops until a pop.
    grants = 0;
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_grants", 64'(grants), 64'd4);
    chk("bp_req_low", 64'(mem_req_o), 64'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Redirect with 3 fetches in flight at L=5.
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Redirect in the same cycle as a response (L=3, third cycle after first grant).
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 32'h8000_0200, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Grant stall keeps the request stable, then PC wrap after a redirect.
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    lat_min = 1; lat_max = 1;
    tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Held redirect: the last PC wins.
    tick(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Response with nothing outstanding is ignored.
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-stream with the FIFO non-empty.
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 64'(inst_valid_o), 64'd1);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(inst_valid_o), 64'd0);
    chk("arst_addr", 64'(mem_addr_o), 64'(RPC));
    chk("arst_req", 64'(mem_req_o), 64'd1);
    chk("arst_inst", 64'(inst_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); cyc++; #1;
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();

    // Random traffic with variable latency, stalls, back-pressure and redirects.
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 800; i++) begin
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) rp = 32'hFFFF_FFF0;
      tick($urandom_range(19, 0) == 0, rp, $urandom_range(9, 0) < 7,
           $urandom_range(3, 0) != 0, 1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
